// File: rtl/alu_issue_if.sv
// Instruction, result and ALU-port bundle for the alu_issue execute stage.
// master drives instructions, alu_out and res_ready; slave is the issue block.
interface alu_issue_if #(
  parameter int unsigned REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_ra;
  logic [REG_AW-1:0] in_rb;
  logic              in_use_imm;
  logic [15:0]       in_imm;

  logic [3:0]        alu_opcode;
  logic [31:0]       alu_left;
  logic [31:0]       alu_right;
  logic [31:0]       alu_out;

  logic              res_valid;
  logic              res_ready;
  logic [REG_AW-1:0] res_rd;
  logic [31:0]       res_data;

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, alu_out, res_ready,
    input  in_ready, alu_opcode, alu_left, alu_right, res_valid, res_rd, res_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, alu_out, res_ready,
    output in_ready, alu_opcode, alu_left, alu_right, res_valid, res_rd, res_data
  );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage driver for the CPU32 ALU: E stage reads a local register file and feeds the
// external ALU, WB stage holds the result until the consumer accepts it, then writes it back.
module alu_issue #(
  parameter int unsigned REG_AW  = 4,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_issue_if.slave  bus
);
  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic              e_valid_q;
  logic [3:0]        e_op_q;
  logic [REG_AW-1:0] e_rd_q;
  logic [REG_AW-1:0] e_ra_q;
  logic [REG_AW-1:0] e_rb_q;
  logic              e_use_imm_q;
  logic [15:0]       e_imm_q;

  logic              res_valid_q;
  logic [REG_AW-1:0] res_rd_q;
  logic [31:0]       res_data_q;

  logic [31:0]       rf_q [NumRegs];

  logic              wb_free;
  logic              e_adv;
  logic              accept;
  logic              commit;
  logic [31:0]       left;
  logic [31:0]       right;

  always_comb begin
    wb_free = !res_valid_q || bus.res_ready;
    e_adv   = e_valid_q && wb_free;
    accept  = bus.in_valid && (!e_valid_q || wb_free);
    commit  = res_valid_q && bus.res_ready;
  end

  // Pending WB result overrides the register file; r0 is hardwired to zero when enabled.
  always_comb begin
    left = rf_q[e_ra_q];
    if (res_valid_q && (res_rd_q == e_ra_q)) left = res_data_q;
    if (ZERO_R0 && (e_ra_q == '0)) left = '0;

    right = rf_q[e_rb_q];
    if (res_valid_q && (res_rd_q == e_rb_q)) right = res_data_q;
    if (ZERO_R0 && (e_rb_q == '0)) right = '0;
    if (e_use_imm_q) right = {16'h0, e_imm_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid_q   <= 1'b0;
      e_op_q      <= '0;
      e_rd_q      <= '0;
      e_ra_q      <= '0;
      e_rb_q      <= '0;
      e_use_imm_q <= 1'b0;
      e_imm_q     <= '0;
    end else if (accept) begin
      e_valid_q   <= 1'b1;
      e_op_q      <= bus.in_op;
      e_rd_q      <= bus.in_rd;
      e_ra_q      <= bus.in_ra;
      e_rb_q      <= bus.in_rb;
      e_use_imm_q <= bus.in_use_imm;
      e_imm_q     <= bus.in_imm;
    end else if (e_adv) begin
      // Fields are kept so the ALU ports hold the last instruction while E is empty.
      e_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
    end else if (e_adv) begin
      res_valid_q <= 1'b1;
      res_rd_q    <= e_rd_q;
      res_data_q  <= bus.alu_out;
    end else if (commit) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (commit && !(ZERO_R0 && (res_rd_q == '0))) begin
      rf_q[res_rd_q] <= res_data_q;
    end
  end

  assign bus.in_ready   = !e_valid_q || wb_free;
  assign bus.alu_opcode = e_op_q;
  assign bus.alu_left   = left;
  assign bus.alu_right  = right;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_rd     = res_rd_q;
  assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU on the alu_* ports.
module tb_alu_issue;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpMov = 4'b1110;
  localparam logic [3:0] OpHi  = 4'b1111;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  alu_issue_if #(.REG_AW(4)) bus ();

  alu_issue #(.REG_AW(4), .ZERO_R0(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: mov passes right, 1111 packs right[15:0] over left[15:0].
  always_comb begin
    unique case (bus.alu_opcode)
      OpAdd:   bus.alu_out = bus.alu_left + bus.alu_right;
      OpSub:   bus.alu_out = bus.alu_left - bus.alu_right;
      OpOr:    bus.alu_out = bus.alu_left | bus.alu_right;
      OpMov:   bus.alu_out = bus.alu_right;
      OpHi:    bus.alu_out = {bus.alu_right[15:0], bus.alu_left[15:0]};
      default: bus.alu_out = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic use_imm, input logic [15:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_ra      = ra;
    bus.in_rb      = rb;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rd      = '0;
    bus.in_ra      = '0;
    bus.in_rb      = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.res_ready  = 1'b1;
    #22 reset_n = 1'b1;
    step();

    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst res_data", bus.res_data, 32'h0);
    check("rst alu_opcode", 32'(bus.alu_opcode), 32'h0);
    check("rst alu_left", bus.alu_left, 32'h0);
    check("rst alu_right", bus.alu_right, 32'h0);

    // 1: mov r1 = 0x1234, latency and writeback
    drive(OpMov, 4'd1, 4'd0, 4'd0, 1'b1, 16'h1234);
    step();
    idle();
    check("t1 alu_opcode", 32'(bus.alu_opcode), 32'(OpMov));
    check("t1 alu_right", bus.alu_right, 32'h1234);
    check("t1 res_valid early", 32'(bus.res_valid), 32'd0);
    step();
    check("t1 res_valid", 32'(bus.res_valid), 32'd1);
    check("t1 res_rd", 32'(bus.res_rd), 32'd1);
    check("t1 res_data", bus.res_data, 32'h0000_1234);
    step();
    check("t1 res_valid after commit", 32'(bus.res_valid), 32'd0);
    check("t1 rf1", dut.rf_q[1], 32'h1234);

    // 2: back-to-back forwarding chain
    drive(OpMov, 4'd1, 4'd0, 4'd0, 1'b1, 16'd5);
    step();
    drive(OpAdd, 4'd2, 4'd1, 4'd1, 1'b0, 16'd0);
    step();
    drive(OpSub, 4'd3, 4'd2, 4'd1, 1'b0, 16'd0);
    check("t2 res0 data", bus.res_data, 32'd5);
    check("t2 res0 rd", 32'(bus.res_rd), 32'd1);
    step();
    idle();
    check("t2 res1 data", bus.res_data, 32'd10);
    check("t2 res1 rd", 32'(bus.res_rd), 32'd2);
    step();
    check("t2 res2 data", bus.res_data, 32'd5);
    check("t2 res2 rd", 32'(bus.res_rd), 32'd3);
    step();
    check("t2 drained", 32'(bus.res_valid), 32'd0);
    check("t2 rf3", dut.rf_q[3], 32'd5);

    // 3: backpressure for three cycles with three instructions offered
    bus.res_ready = 1'b0;
    drive(OpMov, 4'd4, 4'd0, 4'd0, 1'b1, 16'd1);
    step();
    drive(OpMov, 4'd5, 4'd0, 4'd0, 1'b1, 16'd2);
    step();
    drive(OpMov, 4'd6, 4'd0, 4'd0, 1'b1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3 in_ready stall%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("t3 res_data stall%0d", i), bus.res_data, 32'd1);
      check($sformatf("t3 alu_right stall%0d", i), bus.alu_right, 32'd2);
      if (i < 2) step();
    end
    bus.res_ready = 1'b1;
    #1;
    check("t3 in_ready release", 32'(bus.in_ready), 32'd1);
    step();
    idle();
    check("t3 res rd5", 32'(bus.res_rd), 32'd5);
    check("t3 res data2", bus.res_data, 32'd2);
    step();
    check("t3 res rd6", 32'(bus.res_rd), 32'd6);
    check("t3 res data3", bus.res_data, 32'd3);
    step();
    check("t3 drained", 32'(bus.res_valid), 32'd0);
    check("t3 rf4", dut.rf_q[4], 32'd1);
    check("t3 rf5", dut.rf_q[5], 32'd2);
    check("t3 rf6", dut.rf_q[6], 32'd3);

    // 4: r0 writes dropped, r0 reads zero
    drive(OpMov, 4'd0, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    step();
    drive(OpOr, 4'd4, 4'd0, 4'd0, 1'b0, 16'd0);
    step();
    idle();
    check("t4 r0 res data", bus.res_data, 32'h0000_FFFF);
    check("t4 r0 res rd", 32'(bus.res_rd), 32'd0);
    step();
    check("t4 or res rd", 32'(bus.res_rd), 32'd4);
    check("t4 or res data", bus.res_data, 32'd0);
    step();
    check("t4 drained", 32'(bus.res_valid), 32'd0);
    check("t4 rf0", dut.rf_q[0], 32'd0);
    check("t4 rf4", dut.rf_q[4], 32'd0);

    // 5: opcode 1111 packs immediate above r1's low half
    drive(OpMov, 4'd1, 4'd0, 4'd0, 1'b1, 16'h1234);
    step();
    drive(OpHi, 4'd5, 4'd1, 4'd0, 1'b1, 16'hABCD);
    step();
    idle();
    step();
    check("t5 res rd", 32'(bus.res_rd), 32'd5);
    check("t5 res data", bus.res_data, 32'hABCD_1234);
    step();
    check("t5 rf5", dut.rf_q[5], 32'hABCD_1234);

    // 6: reset with both stages occupied
    bus.res_ready = 1'b0;
    drive(OpMov, 4'd7, 4'd0, 4'd0, 1'b1, 16'h0011);
    step();
    drive(OpMov, 4'd8, 4'd0, 4'd0, 1'b1, 16'h0022);
    step();
    idle();
    check("t6 pre res_valid", 32'(bus.res_valid), 32'd1);
    check("t6 pre in_ready", 32'(bus.in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t6 rst res_valid", 32'(bus.res_valid), 32'd0);
    check("t6 rst in_ready", 32'(bus.in_ready), 32'd1);
    check("t6 rst rf1", dut.rf_q[1], 32'd0);
    check("t6 rst rf5", dut.rf_q[5], 32'd0);
    check("t6 rst alu_opcode", 32'(bus.alu_opcode), 32'd0);
    #1 reset_n = 1'b1;
    bus.res_ready = 1'b1;
    step();
    drive(OpAdd, 4'd2, 4'd1, 4'd0, 1'b1, 16'd3);
    step();
    idle();
    step();
    check("t6 post res rd", 32'(bus.res_rd), 32'd2);
    check("t6 post res data", bus.res_data, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
